push_event_decoder: RTL and testbench
=====================================

# push_event_decoder

Converts the stretched, debounced button level `push` into discrete, timestamped key events for the music-game judge logic. It sits downstream of the per-lane button stretcher and upstream of the note-hit judge. It confirms press and release edges over a settle window and flags long presses. Each event is delivered through a one-entry valid/ready buffer together with its elapsed hold length.

## Interface
- `SETTLE`, default 4: cycles a new level must persist before an edge is confirmed; legal range 2..2^CNT_W-1.
- `LONG`, default 50000000: hold length in cycles that triggers a long-press event; must be > SETTLE.
- `CNT_W`, default 28: width of the hold-length counter.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `push`  in  1  button level, synchronous to CLK. No synchronizer is instantiated.
- `held`  out  1  high while the button is confirmed pressed (states HELD, LONG_HELD, CONFIRM_OFF).
- `evt_valid`  out  1  event buffer holds an event.
- `evt_ready`  in  1  consumer accepts the event when `evt_valid && evt_ready`.
- `evt_code`  out  2  event type: 01 PRESS, 10 LONG, 11 RELEASE. 00 is never issued while valid.
- `evt_len`  out  CNT_W  hold length captured with the event.
- `ovf`  out  1  sticky: an event was dropped because the buffer was full. Cleared only by RST.

## Operation
- **FSM states:** IDLE, CONFIRM_ON, HELD, LONG_HELD, CONFIRM_OFF.
- **Counters:**
  - `cnt` is the settle counter, CNT_W bits.
  - `len` is the hold counter, CNT_W bits. It saturates at all-ones and never wraps.
  - A `was_long` flag records whether the press had reached LONG_HELD before entering CONFIRM_OFF.
- **IDLE:**
  - `push`=1 → CONFIRM_ON, with `cnt`=1 and `len`=1.
  - Otherwise stay, with `len`=0.
- **CONFIRM_ON:**
  - `push`=0 → IDLE. This is a glitch: no event, `len` cleared.
  - `push`=1 and `cnt`==SETTLE-1 → HELD, and emit PRESS.
  - Otherwise `cnt`+1.
- **HELD:**
  - `push`=0 → CONFIRM_OFF, with `cnt`=1 and `was_long`=0.
  - `push`=1 and `len`>=LONG-1 → LONG_HELD, and emit LONG.
- **LONG_HELD:**
  - `push`=0 → CONFIRM_OFF, with `cnt`=1 and `was_long`=1.
- **CONFIRM_OFF:**
  - `push`=1 → HELD if `was_long`=0, LONG_HELD if `was_long`=1. No event is emitted. A bounce re-entering HELD with `len`>=LONG-1 still produces LONG on the next qualifying cycle.
  - `push`=0 and `cnt`==SETTLE-1 → IDLE, and emit RELEASE.
  - Otherwise `cnt`+1.
- **Hold counter:** `len` increments (saturating) on every edge at which the FSM is not in IDLE, including the edge leaving to IDLE.
- **Event capture:** the emitted `evt_len` is the post-increment `len` of the emitting edge. For a clean press held high for N cycles, PRESS reports SETTLE, LONG reports LONG, and RELEASE reports N+SETTLE (saturated).
- **Event buffer:**
  - Load when an event is emitted and (`evt_valid`=0 or `evt_ready`=1).
  - Emit with `evt_valid && !evt_ready`: the new event is dropped, `ovf` is set, and the buffer contents are unchanged.
  - Accept with no new event: `evt_valid` → 0, while `evt_code`/`evt_len` hold their last values.
  - Accept and emit in the same cycle: load the new event, `evt_valid` stays 1.

## Timing
- Reset values: state IDLE, `cnt`=0, `len`=0, `was_long`=0, `held`=0, `evt_valid`=0, `evt_code`=00, `evt_len`=0, `ovf`=0.
- RST asserted mid-press or with a pending event discards everything immediately. No RELEASE is generated.
- All outputs are registered, or decoded from registered state only. There is no combinational path from `push` or `evt_ready` to any output.
- **PRESS latency:** `evt_valid` rises SETTLE edges after the first edge that samples `push`=1. `held` rises on the same edge.
- **RELEASE latency:** SETTLE edges after the first edge sampling `push`=0 in HELD or LONG_HELD. `held` falls on the same edge.
- The minimum event spacing is SETTLE cycles. A consumer holding `evt_ready`=1 never causes `ovf`.

## Test plan
- **Clean press** (SETTLE=4, LONG=10, `evt_ready`=1): `push` high for cycles 0..19, low after.
  - PRESS with `evt_len`=4 valid after edge 3.
  - LONG with `evt_len`=10 after edge 9.
  - RELEASE with `evt_len`=24 after edge 23.
  - `held` is high from after edge 3 to after edge 23.
- **Glitch** (SETTLE=4): `push` high 2 cycles, then low → no event, `held` stays 0, and the FSM is back in IDLE after edge 2.
- **Release bounce** (SETTLE=4, LONG=100): press for 20 cycles, then `push` low 2 cycles, high 1, low steady → exactly one PRESS and one RELEASE, `held` never drops during the bounce, and there is no LONG.
- **Backpressure** (`evt_ready`=0 throughout): short press, then release → PRESS is held in the buffer, RELEASE is dropped, and `ovf`=1. Asserting `evt_ready` for one cycle then clears `evt_valid`.
- **Accept and emit in the same cycle:** `evt_ready` pulses on the exact edge LONG is emitted while PRESS is pending → `evt_valid` stays 1, `evt_code` becomes 10, and `ovf` stays 0.
- **Asynchronous reset mid-press:** assert RST while in LONG_HELD with an event pending → all outputs go to their reset values before the next CLK edge, and no RELEASE follows after RST deasserts with `push`=0.

Source files
------------

// File: rtl/push_event_decoder.sv
// Turns a debounced button level into PRESS / LONG / RELEASE events, each
// tagged with the hold length, delivered through a one-entry valid/ready buffer.
module push_event_decoder #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned LONG   = 50000000,
    parameter int unsigned CNT_W  = 28
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    output logic             held,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [1:0]       evt_code,
    output logic [CNT_W-1:0] evt_len,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM_ON,
        S_HELD,
        S_LONG_HELD,
        S_CONFIRM_OFF
    } state_t;

    localparam logic [1:0]       EVT_PRESS   = 2'b01;
    localparam logic [1:0]       EVT_LONG    = 2'b10;
    localparam logic [1:0]       EVT_RELEASE = 2'b11;
    localparam logic [CNT_W-1:0] SETTLE_M1   = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LONG_M1     = CNT_W'(LONG - 1);
    localparam logic [CNT_W-1:0] LEN_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             was_long_q, was_long_d;
    logic             held_q, held_d;
    logic             evt_valid_q, evt_valid_d;
    logic [1:0]       evt_code_q, evt_code_d;
    logic [CNT_W-1:0] evt_len_q, evt_len_d;
    logic             ovf_q, ovf_d;
    logic             emit;
    logic [1:0]       emit_code;

    // Next-state, counters, and event buffer update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        was_long_d  = was_long_q;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_len_d   = evt_len_q;
        ovf_d       = ovf_q;
        emit        = 1'b0;
        emit_code   = EVT_PRESS;

        if (state_q != S_IDLE) begin
            len_d = (len_q == LEN_MAX) ? len_q : len_q + ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (push) begin
                    state_d = S_CONFIRM_ON;
                    cnt_d   = ONE;
                    len_d   = ONE;
                end else begin
                    len_d = '0;
                end
            end
            S_CONFIRM_ON: begin
                if (!push) begin
                    state_d = S_IDLE;
                    len_d   = '0;
                end else if (cnt_q == SETTLE_M1) begin
                    state_d   = S_HELD;
                    emit      = 1'b1;
                    emit_code = EVT_PRESS;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_HELD: begin
                if (!push) begin
                    state_d    = S_CONFIRM_OFF;
                    cnt_d      = ONE;
                    was_long_d = 1'b0;
                end else if (len_q >= LONG_M1) begin
                    state_d   = S_LONG_HELD;
                    emit      = 1'b1;
                    emit_code = EVT_LONG;
                end
            end
            S_LONG_HELD: begin
                if (!push) begin
                    state_d    = S_CONFIRM_OFF;
                    cnt_d      = ONE;
                    was_long_d = 1'b1;
                end
            end
            S_CONFIRM_OFF: begin
                // A bounce resumes the press without re-announcing it
                if (push) begin
                    state_d = was_long_q ? S_LONG_HELD : S_HELD;
                end else if (cnt_q == SETTLE_M1) begin
                    state_d   = S_IDLE;
                    emit      = 1'b1;
                    emit_code = EVT_RELEASE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        held_d = (state_d == S_HELD) || (state_d == S_LONG_HELD) ||
                 (state_d == S_CONFIRM_OFF);

        // A full, unaccepted buffer drops the new event and flags it
        if (emit) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_code_d  = emit_code;
                evt_len_d   = len_d;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            len_q       <= '0;
            was_long_q  <= 1'b0;
            held_q      <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 2'b00;
            evt_len_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            was_long_q  <= was_long_d;
            held_q      <= held_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_len_q   <= evt_len_d;
            ovf_q       <= ovf_d;
        end
    end

    assign held      = held_q;
    assign evt_valid = evt_valid_q;
    assign evt_code  = evt_code_q;
    assign evt_len   = evt_len_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_push_event_decoder.sv
// Scoreboard bench for push_event_decoder: a run-length model of the button
// predicts events; a negedge monitor checks every accepted event and flag.
module tb_push_event_decoder;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned LONG   = 10;
    localparam int unsigned CNT_W  = 6;
    localparam int          MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             held;
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_code;
    logic [CNT_W-1:0] evt_len;
    logic             ovf;

    typedef struct packed {
        logic [1:0]       code;
        logic [CNT_W-1:0] len;
    } evt_t;

    evt_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: confirmed level, count of disagreeing samples, hold length
    bit m_pressed, m_long, m_valid, m_ovf;
    int m_run, m_len;

    push_event_decoder #(.SETTLE(SETTLE), .LONG(LONG), .CNT_W(CNT_W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .push      (push),
        .held      (held),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_len   (evt_len),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pressed = 0; m_long = 0; m_valid = 0; m_ovf = 0;
        m_run = 0; m_len = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit p, input bit r);
        bit       idle_before, stable_held, emit;
        int       len_before;
        logic [1:0] code;
        evt_t     e;
        idle_before = !m_pressed && (m_run == 0);
        stable_held = m_pressed && (m_run == 0);
        len_before  = m_len;
        emit        = 0;
        code        = 2'b00;
        if (idle_before) m_len = p ? 1 : 0;
        else if (m_len < MAXV) m_len++;

        if (p != m_pressed) begin
            m_run++;
        end else begin
            if (!m_pressed && m_run > 0) m_len = 0;
            m_run = 0;
        end

        if (m_run == int'(SETTLE)) begin
            m_pressed = !m_pressed;
            m_run     = 0;
            emit      = 1;
            code      = m_pressed ? 2'b01 : 2'b11;
            if (!m_pressed) m_long = 0;
        end else if (stable_held && p && !m_long && len_before >= int'(LONG) - 1) begin
            m_long = 1;
            emit   = 1;
            code   = 2'b10;
        end

        if (emit) begin
            if (!m_valid || r) begin
                m_valid = 1;
                e.code  = code;
                e.len   = CNT_W'(m_len);
                exp_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit p, input bit r);
        push      = p;
        evt_ready = r;
        @(posedge clk);
        if (!rst) model_step(p, r);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        push      = 1'b0;
        evt_ready = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        check("rst_held", held, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_len", evt_len, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        #1;
    endtask

    // Monitor: flags every cycle, and pops the scoreboard on each accept
    always @(negedge clk) begin
        if (!rst) begin
            evt_t e;
            check("held", held, m_pressed);
            check("evt_valid", evt_valid, m_valid);
            check("ovf", ovf, m_ovf);
            if (evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: got code %0h len %0d expected none at %0t",
                             evt_code, evt_len, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("evt_code", evt_code, e.code);
                    check("evt_len", evt_len, e.len);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; push = 1'b0; evt_ready = 1'b0;
        #3;
        apply_reset();

        // Clean press: high for 20 cycles, released after
        for (int i = 0; i < 30; i++) begin
            step(i < 20, 1'b1);
            if (i == 2) check("clean_held_pre", held, 0);
            if (i == 3) begin
                check("clean_press_code", evt_code, 2'b01);
                check("clean_press_len", evt_len, 4);
                check("clean_held", held, 1);
            end
            if (i == 9) begin
                check("clean_long_code", evt_code, 2'b10);
                check("clean_long_len", evt_len, 10);
            end
            if (i == 22) check("clean_held_late", held, 1);
            if (i == 23) begin
                check("clean_rel_code", evt_code, 2'b11);
                check("clean_rel_len", evt_len, 24);
                check("clean_held_off", held, 0);
            end
        end

        // Glitch: two high cycles produce nothing
        for (int i = 0; i < 12; i++) step(i < 2, 1'b1);
        check("glitch_valid", evt_valid, 0);

        // Release bounce: low 2, high 1, low steady
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        check("bounce_held", held, 1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        check("bounce_code", evt_code, 2'b11);

        // Backpressure: RELEASE dropped, PRESS kept
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
        check("bp_code", evt_code, 2'b01);
        check("bp_ovf", ovf, 1);
        step(1'b0, 1'b1);
        check("bp_cleared", evt_valid, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        apply_reset();

        // Accept and emit together, then async reset in LONG_HELD
        for (int i = 0; i < 15; i++) begin
            step(1'b1, i == 9);
            if (i == 9) begin
                check("ae_valid", evt_valid, 1);
                check("ae_code", evt_code, 2'b10);
                check("ae_ovf", ovf, 0);
            end
        end
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("async_held", held, 0);
        check("async_valid", evt_valid, 0);
        check("async_code", evt_code, 0);
        check("async_len", evt_len, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1);
        check("async_no_release", evt_valid, 0);

        // Saturation of the hold length
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        check("sat_code", evt_code, 2'b11);
        check("sat_len", evt_len, MAXV);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);

        // Random runs with a ready consumer, then random backpressure
        for (int phase = 0; phase < 2; phase++) begin
            for (int b = 0; b < 150; b++) begin
                bit lvl;
                int run;
                lvl = 1'($urandom_range(0, 1));
                run = (b % 10 == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 12));
                for (int k = 0; k < run; k++)
                    step(lvl, phase == 0 ? 1'b1 : ($urandom_range(0, 9) < 7));
            end
            for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
            check("drain_empty", exp_q.size(), 0);
            if (phase == 0) check("ready_no_ovf", ovf, 0);
            apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
